i2s_tx_unpacker: RTL and testbench
==================================

# i2s_tx_unpacker

Sample unpacker between the uDMA TX stream and the I2S TX sample FIFO, in the system clock domain. It accepts 32-bit words from the uDMA TX channel and splits each word into one, two or four audio samples of 32, 16 or 8 bits. Each sample is zero- or sign-extended to 32 bits and presented on a valid/ready stream to the dual-clock FIFO. The I2S serializer reads that FIFO in the sck domain. The block also counts FIFO-side underruns.

## Interface
- UNDERRUN_CNT_W, 16, width of the saturating underrun counter.
- clk_i  in  1  system clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- cfg_en_i  in  1  enable; low = synchronous flush and idle.
- cfg_size_i  in  2  sample size: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit, 3 = reserved, treated as 32-bit.
- cfg_sext_i  in  1  1 = sign-extend samples, 0 = zero-extend.
- cfg_msb_first_i  in  1  0 = lowest lane of the word is emitted first, 1 = highest lane first.
- data_tx_i  in  32  word from uDMA TX.
- data_tx_valid_i  in  1  word valid.
- data_tx_ready_o  out  1  word accepted when valid & ready.
- sample_o  out  32  extended sample to the TX FIFO.
- sample_valid_o  out  1  sample valid.
- sample_ready_i  in  1  FIFO has space.
- underrun_o  out  1  one-cycle pulse per underrun cycle.
- underrun_cnt_o  out  UNDERRUN_CNT_W  saturating underrun count.

## Operation
- State registers:
  - r_word: 32-bit holding register.
  - r_full: holding register valid.
  - r_idx: 2-bit lane index.
  - r_size: size latched at word load.
  - r_sext, r_msbf: extension and lane order latched at word load.
- Lanes per word: N = 4 / 2 / 1 for r_size = 8-bit / 16-bit / 32-bit; lane width W = 8 / 16 / 32.
- Lane select: lane = r_idx when r_msbf = 0, else N-1-r_idx.
- sample_o = r_word[lane*W +: W], extended to 32 bits per r_sext (zero when r_sext = 0).
- sample_valid_o = r_full & cfg_en_i.
- last = (r_idx == N-1).
- pop = sample_valid_o & sample_ready_i.
- data_tx_ready_o = cfg_en_i & (!r_full | (pop & last)). This is a combinational path from sample_ready_i; it is intended.
- Word load (data_tx_valid_i & data_tx_ready_o): r_word <= data_tx_i, r_full <= 1, r_idx <= 0, and cfg_size_i, cfg_sext_i, cfg_msb_first_i are latched.
- pop with !last: r_idx <= r_idx+1.
- pop with last and no load in the same cycle: r_full <= 0.
- pop with last and a load in the same cycle: the new word replaces the old one with no bubble.
- Config changes affect only the next loaded word. A word already held keeps its latched size and order.
- Underrun: cfg_en_i & sample_ready_i & !r_full.
  - Registered into underrun_o, asserted one cycle later.
  - underrun_cnt_o increments by 1 per underrun cycle and saturates at all-ones.
- cfg_en_i low:
  - r_full <= 0, r_idx <= 0, underrun counter cleared, underrun_o <= 0.
  - data_tx_ready_o = 0 and sample_valid_o = 0 combinationally, in that same cycle.
  - A partially consumed word is discarded.

## Timing
- Reset values:
  - r_full = 0, r_idx = 0, r_word = 0, r_size = 0, r_sext = 0, r_msbf = 0.
  - Outputs: data_tx_ready_o = 0, sample_valid_o = 0, sample_o = 0, underrun_o = 0, underrun_cnt_o = 0.
- Latency: a word accepted on edge t produces its first sample on sample_o/sample_valid_o after edge t, i.e. one cycle.
- Throughput with sample_ready_i held high and uDMA words always valid: one sample per cycle. Words are taken every N cycles with no gap between them.
- sample_o and sample_valid_o stay stable while sample_valid_o & !sample_ready_i. The holding register and index do not move.
- Simultaneous cfg_en_i falling and pop: the flush wins. No sample transfers and no word load occur.
- Reset mid-word: all state is cleared asynchronously, no sample is emitted, and the word is lost.

## Test plan
- 8-bit size, sext = 1, msb_first = 0, word 0x8844_2211, ready held high -> samples 0x00000011, 0x00000022, 0x00000044, 0xFFFFFF88 on 4 consecutive cycles; data_tx_ready_o high on the 4th cycle.
- 16-bit size, sext = 0, msb_first = 1, words 0xABCD_1234 then 0x0001_8000 back-to-back -> samples 0x0000ABCD, 0x00001234, 0x00000001, 0x00008000 with no idle cycle.
- 32-bit size, sample_ready_i toggling 1,0,0,1 -> each word is emitted unchanged. sample_o stays stable during the stalls, and data_tx_ready_o is asserted only in pop cycles.
- Underrun: enable with no uDMA data and sample_ready_i high for 5 cycles -> 5 underrun_o pulses, each one cycle late; count = 5. With UNDERRUN_CNT_W = 2, the count saturates at 3.
- Flush: 8-bit word loaded, 2 samples popped, then cfg_en_i low for 1 cycle and high again -> sample_valid_o = 0 in the low cycle, the remaining 2 samples are never emitted, and the counter reads 0.
- Config change mid-word: 8-bit word held, cfg_size_i switched to 32-bit after the first pop -> 3 more 8-bit samples, then the next word is emitted as a single 32-bit sample.

Source files
------------

// File: rtl/i2s_tx_unpacker.sv
// Splits 32-bit uDMA TX words into 8/16/32-bit samples, extends them to 32 bits
// and streams them towards the I2S TX FIFO; also counts FIFO-side underruns.
module i2s_tx_unpacker #(
  parameter int unsigned UNDERRUN_CNT_W = 16
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      cfg_en_i,
  input  logic [1:0]                cfg_size_i,
  input  logic                      cfg_sext_i,
  input  logic                      cfg_msb_first_i,
  input  logic [31:0]               data_tx_i,
  input  logic                      data_tx_valid_i,
  output logic                      data_tx_ready_o,
  output logic [31:0]               sample_o,
  output logic                      sample_valid_o,
  input  logic                      sample_ready_i,
  output logic                      underrun_o,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt_o
);

  logic [31:0]               word_q, word_d;
  logic                      full_q, full_d;
  logic [1:0]                idx_q, idx_d;
  logic [1:0]                size_q, size_d;
  logic                      sext_q, sext_d;
  logic                      msbf_q, msbf_d;
  logic                      underrun_q, underrun_d;
  logic [UNDERRUN_CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]  last_idx;
  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        last;
  logic        pop;
  logic        load;
  logic        underrun_now;

  // Size codes 2 and 3 both mean one 32-bit lane per word.
  always_comb begin
    case (size_q)
      2'd0:    last_idx = 2'd3;
      2'd1:    last_idx = 2'd1;
      default: last_idx = 2'd0;
    endcase
  end

  assign lane     = msbf_q ? (last_idx - idx_q) : idx_q;
  assign byte_sel = word_q[{lane, 3'b000} +: 8];
  assign half_sel = word_q[{lane[0], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      2'd0:    sample_o = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'd1:    sample_o = {{16{sext_q & half_sel[15]}}, half_sel};
      default: sample_o = word_q;
    endcase
  end

  assign last            = (idx_q == last_idx);
  assign sample_valid_o  = full_q & cfg_en_i;
  assign pop             = sample_valid_o & sample_ready_i;
  assign data_tx_ready_o = cfg_en_i & (~full_q | (pop & last));
  assign load            = data_tx_valid_i & data_tx_ready_o;
  assign underrun_now    = cfg_en_i & sample_ready_i & ~full_q;

  always_comb begin
    word_d     = word_q;
    full_d     = full_q;
    idx_d      = idx_q;
    size_d     = size_q;
    sext_d     = sext_q;
    msbf_d     = msbf_q;
    underrun_d = underrun_q;
    cnt_d      = cnt_q;
    if (!cfg_en_i) begin
      // Disabling drops any partially consumed word.
      full_d     = 1'b0;
      idx_d      = 2'd0;
      underrun_d = 1'b0;
      cnt_d      = '0;
    end else begin
      underrun_d = underrun_now;
      if (underrun_now && (cnt_q != {UNDERRUN_CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (pop) begin
        if (last) begin
          full_d = 1'b0;
          idx_d  = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      // A load can only coincide with the last pop, so it overrides cleanly.
      if (load) begin
        word_d = data_tx_i;
        full_d = 1'b1;
        idx_d  = 2'd0;
        size_d = cfg_size_i;
        sext_d = cfg_sext_i;
        msbf_d = cfg_msb_first_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      word_q     <= '0;
      full_q     <= 1'b0;
      idx_q      <= 2'd0;
      size_q     <= 2'd0;
      sext_q     <= 1'b0;
      msbf_q     <= 1'b0;
      underrun_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      word_q     <= word_d;
      full_q     <= full_d;
      idx_q      <= idx_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      msbf_q     <= msbf_d;
      underrun_q <= underrun_d;
      cnt_q      <= cnt_d;
    end
  end

  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = cnt_q;

endmodule

// File: tb/tb_i2s_tx_unpacker.sv
// Randomized bench for i2s_tx_unpacker: a queue of expected samples filled on
// word acceptance and drained by a monitor that checks every cycle.
module tb_i2s_tx_unpacker;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_en;
  logic [1:0]  cfg_size;
  logic        cfg_sext;
  logic        cfg_msbf;
  logic [31:0] data_tx;
  logic        data_tx_valid;
  logic        sample_ready;

  logic        data_tx_ready, data_tx_ready2;
  logic [31:0] sample, sample2;
  logic        sample_valid, sample_valid2;
  logic        underrun, underrun2;
  logic [15:0] underrun_cnt;
  logic [1:0]  underrun_cnt2;

  always #5 clk = ~clk;

  i2s_tx_unpacker #(.UNDERRUN_CNT_W(16)) u_dut (
    .clk_i(clk), .rstn_i(rstn), .cfg_en_i(cfg_en), .cfg_size_i(cfg_size),
    .cfg_sext_i(cfg_sext), .cfg_msb_first_i(cfg_msbf), .data_tx_i(data_tx),
    .data_tx_valid_i(data_tx_valid), .data_tx_ready_o(data_tx_ready),
    .sample_o(sample), .sample_valid_o(sample_valid), .sample_ready_i(sample_ready),
    .underrun_o(underrun), .underrun_cnt_o(underrun_cnt)
  );

  // Narrow-counter instance, used only to observe saturation.
  i2s_tx_unpacker #(.UNDERRUN_CNT_W(2)) u_dut_sat (
    .clk_i(clk), .rstn_i(rstn), .cfg_en_i(cfg_en), .cfg_size_i(cfg_size),
    .cfg_sext_i(cfg_sext), .cfg_msb_first_i(cfg_msbf), .data_tx_i(data_tx),
    .data_tx_valid_i(data_tx_valid), .data_tx_ready_o(data_tx_ready2),
    .sample_o(sample2), .sample_valid_o(sample_valid2), .sample_ready_i(sample_ready),
    .underrun_o(underrun2), .underrun_cnt_o(underrun_cnt2)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  logic [31:0] dummy;
  bit          exp_ur = 1'b0;
  int          exp_cnt = 0;
  int          exp_cnt2 = 0;
  bit          exp_valid, exp_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Samples of a word from the lane rules: N lanes of 32/N bits, order by msb_first.
  function automatic void push_word(input logic [31:0] w, input logic [1:0] sz,
                                    input bit sx, input bit mf);
    int n;
    int wd;
    logic [63:0] mask;
    logic [63:0] v;
    n = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
    wd = 32 / n;
    mask = (64'd1 << wd) - 64'd1;
    for (int k = 0; k < n; k++) begin
      int ln;
      ln = mf ? (n - 1 - k) : k;
      v = ({32'd0, w} >> (ln * wd)) & mask;
      if (sx && v[wd-1]) v = v | ~mask;
      exp_q.push_back(v[31:0]);
    end
  endfunction

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      exp_ur = 1'b0;
      exp_cnt = 0;
      exp_cnt2 = 0;
      check("rst_sample", sample, 32'd0);
    end
    exp_valid = cfg_en && (exp_q.size() > 0);
    exp_ready = cfg_en && ((exp_q.size() == 0) || (exp_q.size() == 1 && sample_ready));
    check("sample_valid", {31'd0, sample_valid}, {31'd0, exp_valid});
    check("data_tx_ready", {31'd0, data_tx_ready}, {31'd0, exp_ready});
    if (exp_valid) check("sample", sample, exp_q[0]);
    check("underrun", {31'd0, underrun}, {31'd0, exp_ur});
    check("underrun_cnt", {16'd0, underrun_cnt}, exp_cnt);
    check("underrun_cnt_sat", {30'd0, underrun_cnt2}, exp_cnt2);
    if (rstn) begin
      if (!cfg_en) begin
        exp_q.delete();
        exp_ur = 1'b0;
        exp_cnt = 0;
        exp_cnt2 = 0;
      end else begin
        exp_ur = sample_ready && (exp_q.size() == 0);
        if (exp_ur) begin
          if (exp_cnt < 65535) exp_cnt++;
          if (exp_cnt2 < 3) exp_cnt2++;
        end
        if (exp_q.size() > 0 && sample_ready) dummy = exp_q.pop_front();
        if (data_tx_valid && exp_ready) push_word(data_tx, cfg_size, cfg_sext, cfg_msbf);
      end
    end
  end

  task automatic cyc(input bit en, input bit v, input logic [31:0] d, input bit r);
    @(posedge clk);
    #1;
    cfg_en = en;
    data_tx_valid = v;
    data_tx = d;
    sample_ready = r;
  endtask

  task automatic set_cfg(input logic [1:0] sz, input bit sx, input bit mf);
    cfg_size = sz;
    cfg_sext = sx;
    cfg_msbf = mf;
  endtask

  initial begin
    rstn = 1'b0;
    cfg_en = 1'b0;
    data_tx_valid = 1'b0;
    data_tx = 32'd0;
    sample_ready = 1'b0;
    set_cfg(2'd0, 1'b0, 1'b0);
    repeat (3) cyc(0, 0, 32'd0, 0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // 8-bit, sign-extended, lowest lane first
    set_cfg(2'd0, 1'b1, 1'b0);
    cyc(1, 1, 32'h8844_2211, 1);
    repeat (4) cyc(1, 0, 32'd0, 1);
    cyc(0, 0, 32'd0, 0);

    // 16-bit, zero-extended, highest lane first, back-to-back words
    set_cfg(2'd1, 1'b0, 1'b1);
    cyc(1, 1, 32'hABCD_1234, 1);
    repeat (2) cyc(1, 1, 32'h0001_8000, 1);
    repeat (3) cyc(1, 0, 32'd0, 1);
    cyc(0, 0, 32'd0, 0);

    // 32-bit with stalls
    set_cfg(2'd2, 1'b1, 1'b0);
    cyc(1, 1, 32'hDEAD_BEEF, 0);
    cyc(1, 1, 32'h1357_9BDF, 1);
    cyc(1, 1, 32'h1357_9BDF, 0);
    cyc(1, 1, 32'h1357_9BDF, 0);
    cyc(1, 1, 32'h1357_9BDF, 1);
    cyc(1, 0, 32'd0, 0);
    cyc(1, 0, 32'd0, 1);
    cyc(0, 0, 32'd0, 0);

    // Underrun burst of 5, then idle to observe count
    repeat (5) cyc(1, 0, 32'd0, 1);
    repeat (2) cyc(1, 0, 32'd0, 0);

    // Flush mid-word
    set_cfg(2'd0, 1'b0, 1'b0);
    cyc(0, 0, 32'd0, 0);
    cyc(1, 1, 32'hA1B2_C3D4, 0);
    repeat (2) cyc(1, 0, 32'd0, 1);
    cyc(0, 0, 32'd0, 1);
    repeat (2) cyc(1, 0, 32'd0, 0);

    // Config change while a word is held
    set_cfg(2'd0, 1'b1, 1'b1);
    cyc(1, 1, 32'h80FF_7F01, 1);
    cyc(1, 0, 32'd0, 1);
    set_cfg(2'd2, 1'b0, 1'b0);
    repeat (3) cyc(1, 1, 32'hCAFE_F00D, 1);
    repeat (2) cyc(1, 0, 32'd0, 1);

    // Random traffic with a mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0)
        set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc(($urandom_range(0, 29) != 0), 1'($urandom_range(0, 1)), $urandom,
          ($urandom_range(0, 3) != 0));
      if (i == 1500) begin
        #1 rstn = 1'b0;
        repeat (2) cyc(1, 1, $urandom, 1);
        #1 rstn = 1'b1;
      end
    end
    repeat (2) cyc(1, 0, 32'd0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
